// File: rtl/fetch_sequencer_pkg.sv
// Shared core definitions used by the fetch and decode stages.
package fetch_sequencer_pkg;

  localparam int ADDR_W_DEF  = 32;
  localparam int INSTR_W_DEF = 32;

  // sethi 0,%g0 -- architectural no-op used for every bubble
  localparam logic [31:0] NOP_INSTR = 32'h0100_0000;

  // IF/ID bundle as seen by the decode stage (default widths)
  typedef struct packed {
    logic [INSTR_W_DEF-1:0] instr;
    logic [ADDR_W_DEF-1:0]  pc;
    logic                   valid;
  } ifid_t;

endpackage

// File: rtl/fetch_sequencer_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter
  import fetch_sequencer_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // count up on inc, stick at the top value
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)                   count <= '0;
    else if (inc && (count != '1)) count <= count + CNT_W'(1);
  end

endmodule

// File: rtl/fetch_sequencer.sv
// PC/nPC fetch sequencer with delayed-branch redirect and IF/ID register.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int              ADDR_W   = ADDR_W_DEF,
  parameter int              INSTR_W  = INSTR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall_F,
  input  logic               stall_D,
  input  logic               branch_taken_ID,
  input  logic [ADDR_W-1:0]  branch_target_ID,
  input  logic               annul_slot_ID,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr_D,
  output logic [ADDR_W-1:0]  pc_D,
  output logic               valid_D,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   annul_cnt
);

  // Same layout as ifid_t, sized by this instance's parameters
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
    logic               valid;
  } ifid_w_t;

  localparam logic [INSTR_W-1:0] NOP = INSTR_W'(NOP_INSTR);

  logic [ADDR_W-1:0] pc, npc, tgt;
  ifid_w_t           ifid;
  logic              adv, any_stall;

  assign adv       = !stall_F && !stall_D;
  assign any_stall = stall_F || stall_D;
  // Targets are word aligned; low bits from ID are ignored
  assign tgt       = {branch_target_ID[ADDR_W-1:2], 2'b00};

  // PC/nPC pair: redirect on a taken branch, otherwise walk nPC forward
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc  <= RESET_PC;
      npc <= RESET_PC + ADDR_W'(4);
    end else if (adv) begin
      if (branch_taken_ID) begin
        pc  <= tgt;
        npc <= tgt + ADDR_W'(4);
      end else begin
        pc  <= npc;
        npc <= npc + ADDR_W'(4);
      end
    end
  end

  // IF/ID: hold on stall_D, bubble on fetch-only stall, squash annulled slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid <= '{instr: NOP, pc: '0, valid: 1'b0};
    end else if (!stall_D) begin
      if (stall_F)            ifid <= '{instr: NOP,        pc: ifid.pc, valid: 1'b0};
      else if (annul_slot_ID) ifid <= '{instr: NOP,        pc: pc,      valid: 1'b0};
      else                    ifid <= '{instr: imem_rdata, pc: pc,      valid: 1'b1};
    end
  end

  assign imem_addr = pc;
  assign instr_D   = ifid.instr;
  assign pc_D      = ifid.pc;
  assign valid_D   = ifid.valid;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clr_n (rst_n),
    .inc   (any_stall),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_annul_cnt (
    .clk   (clk),
    .clr_n (rst_n),
    .inc   (adv && annul_slot_ID),
    .count (annul_cnt)
  );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus random traffic vs. a reference model.
module tb_fetch_sequencer;

  localparam int          AW   = 32;
  localparam int          IW   = 32;
  localparam int          CW   = 8;
  localparam logic [31:0] RPC  = 32'h0000_0000;
  localparam logic [31:0] NOP  = 32'h0100_0000;
  localparam logic [CW-1:0] CMAX = '1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          stall_F = 1'b0, stall_D = 1'b0;
  logic          branch_taken_ID = 1'b0, annul_slot_ID = 1'b0;
  logic [AW-1:0] branch_target_ID = '0;
  logic [AW-1:0] imem_addr, pc_D;
  logic [IW-1:0] imem_rdata, instr_D;
  logic          valid_D;
  logic [CW-1:0] stall_cnt, annul_cnt;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  // Instruction memory contents are a fixed function of the address
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign imem_rdata = mem_f(imem_addr);

  fetch_sequencer #(.ADDR_W(AW), .INSTR_W(IW), .RESET_PC(RPC), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .stall_F(stall_F), .stall_D(stall_D),
    .branch_taken_ID(branch_taken_ID), .branch_target_ID(branch_target_ID),
    .annul_slot_ID(annul_slot_ID), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .instr_D(instr_D), .pc_D(pc_D), .valid_D(valid_D),
    .stall_cnt(stall_cnt), .annul_cnt(annul_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: fetch address, next fetch address, what ID holds, event tallies
  logic [31:0] m_pc, m_npc, m_instr, m_pcd;
  logic        m_vld;
  int          m_sc, m_ac;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc <= RPC; m_npc <= RPC + 32'd4;
      m_instr <= NOP; m_pcd <= '0; m_vld <= 1'b0;
      m_sc <= 0; m_ac <= 0;
    end else begin
      if ((stall_F || stall_D) && m_sc < int'(CMAX)) m_sc <= m_sc + 1;
      if (!stall_F && !stall_D) begin
        if (annul_slot_ID && m_ac < int'(CMAX)) m_ac <= m_ac + 1;
        if (branch_taken_ID) begin
          m_pc  <= branch_target_ID & 32'hFFFF_FFFC;
          m_npc <= (branch_target_ID & 32'hFFFF_FFFC) + 32'd4;
        end else begin
          m_pc  <= m_npc;
          m_npc <= m_npc + 32'd4;
        end
        m_pcd   <= m_pc;
        m_instr <= annul_slot_ID ? NOP : mem_f(m_pc);
        m_vld   <= !annul_slot_ID;
      end else if (!stall_D) begin
        m_instr <= NOP;
        m_vld   <= 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("imem_addr", 64'(imem_addr), 64'(m_pc));
      chk("instr_D",   64'(instr_D),   64'(m_instr));
      chk("pc_D",      64'(pc_D),      64'(m_pcd));
      chk("valid_D",   64'(valid_D),   64'(m_vld));
      chk("stall_cnt", 64'(stall_cnt), 64'(m_sc));
      chk("annul_cnt", 64'(annul_cnt), 64'(m_ac));
    end
  end

  task automatic drive(input logic sF, input logic sD, input logic tk,
                       input logic [31:0] tgt, input logic an);
    stall_F = sF; stall_D = sD; branch_taken_ID = tk;
    branch_target_ID = tgt; annul_slot_ID = an;
    @(posedge clk); #1;
  endtask

  initial begin
    // reset state
    #12;
    chk("rst imem_addr", 64'(imem_addr), 64'h0);
    chk("rst instr_D",   64'(instr_D),   64'h0100_0000);
    chk("rst valid_D",   64'(valid_D),   64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_en = 1'b1;
    chk("rel addr0", 64'(imem_addr), 64'h0);
    drive(0, 0, 0, 0, 0);
    chk("rel addr1", 64'(imem_addr), 64'h4);
    chk("rel valid", 64'(valid_D),   64'h1);
    drive(0, 0, 0, 0, 0);
    chk("rel addr2", 64'(imem_addr), 64'h8);
    chk("rel pc_D",  64'(pc_D),      64'h4);

    // load-use stall for two cycles
    drive(1, 1, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    chk("stall addr", 64'(imem_addr), 64'h8);
    chk("stall pc_D", 64'(pc_D),      64'h4);
    chk("stall cnt",  64'(stall_cnt), 64'h2);
    drive(0, 0, 0, 0, 0);
    chk("resume pc_D", 64'(pc_D), 64'h8);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    chk("pre-br pc_D", 64'(pc_D), 64'h10);

    // taken branch, delay slot kept
    drive(0, 0, 1, 32'h100, 0);
    chk("br addr",   64'(imem_addr), 64'h100);
    chk("slot pc_D", 64'(pc_D),      64'h14);
    chk("slot vld",  64'(valid_D),   64'h1);
    drive(0, 0, 0, 0, 0);
    chk("tgt pc_D",  64'(pc_D),      64'h100);
    drive(0, 0, 0, 0, 0);
    chk("tgt+4 pc_D", 64'(pc_D),     64'h104);

    // taken branch, delay slot annulled
    drive(0, 0, 1, 32'h200, 1);
    chk("an pc_D",  64'(pc_D),      64'h108);
    chk("an instr", 64'(instr_D),   64'h0100_0000);
    chk("an vld",   64'(valid_D),   64'h0);
    chk("an cnt",   64'(annul_cnt), 64'h1);
    drive(0, 0, 0, 0, 0);
    chk("an next pc_D", 64'(pc_D), 64'h200);

    // branch held by a decode stall, redirects once released
    drive(0, 1, 1, 32'h300, 0);
    chk("cc addr", 64'(imem_addr), 64'h204);
    chk("cc pc_D", 64'(pc_D),      64'h200);
    drive(0, 0, 1, 32'h300, 0);
    chk("cc redirect", 64'(imem_addr), 64'h300);

    // wrap at top of address space; target low bits ignored
    drive(0, 0, 1, 32'hFFFF_FFFF, 0);
    chk("wrap top", 64'(imem_addr), 64'hFFFF_FFFC);
    drive(0, 0, 0, 0, 0);
    chk("wrap zero", 64'(imem_addr), 64'h0);
    drive(0, 0, 0, 0, 0);
    chk("wrap four", 64'(imem_addr), 64'h4);

    // counter saturation (fetch-only stalls produce bubbles)
    for (int i = 0; i < 300; i++) drive(1, 0, 0, 0, 0);
    chk("sat stall", 64'(stall_cnt), 64'(CMAX));
    chk("sat vld",   64'(valid_D),   64'h0);

    // async reset in the middle of a redirect
    drive(0, 0, 1, 32'h400, 0);
    chk("mid addr", 64'(imem_addr), 64'h400);
    #2 rst_n = 1'b0;
    #1;
    chk("async addr", 64'(imem_addr), 64'(RPC));
    chk("async vld",  64'(valid_D),   64'h0);
    chk("async cnt",  64'(stall_cnt), 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0);
    chk("restart addr", 64'(imem_addr), 64'h4);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0);
        rst_n = 1'b1;
      end else begin
        drive($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
              $urandom_range(0, 2) == 0, $urandom, $urandom_range(0, 3) == 0);
      end
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
